// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a shared KS0108-style LCD bus: captures one command byte,
// generates setup/pulse/hold timing around LCD_en, and supports locked multi-byte bursts.
module lcd_bus_arbiter #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [1:0] cs0,
  input  logic [1:0] cs1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic       di0,
  input  logic       di1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [1:0] LCD_cs,
  output logic       LCD_rw,
  output logic       LCD_di,
  output logic [7:0] LCD_data,
  output logic       LCD_en,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  // Counter reload value: phase length minus one, with 0 treated as 1 and clamped to 255.
  function automatic logic [7:0] reload(input int unsigned n);
    if (n <= 1)        return 8'd0;
    else if (n > 255)  return 8'd254;
    else               return 8'(n - 1);
  endfunction

  localparam logic [7:0] SETUP_LD = reload(SETUP_CYC);
  localparam logic [7:0] PULSE_LD = reload(PULSE_CYC);
  localparam logic [7:0] HOLD_LD  = reload(HOLD_CYC);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       locked_q, locked_d;
  logic       last_q, last_d;
  logic       en_q;
  logic       capture;
  logic       sel;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    last_d   = last_q;
    capture  = 1'b0;
    sel      = owner_q;
    ack0     = 1'b0;
    ack1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (locked_q) begin
          if (owner_q ? req1 : req0) begin
            capture = 1'b1;
            sel     = owner_q;
          end else if (!(owner_q ? lock1 : lock0)) begin
            locked_d = 1'b0;
            last_d   = owner_q;
          end
        end else if (req0 || req1) begin
          capture = 1'b1;
          if (req0 && req1) sel = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
          else              sel = req1;
        end
        if (capture) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          owner_d = sel;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
          ack0    = ~owner_q;
          ack1    = owner_q;
          if (owner_q ? lock1 : lock0) begin
            locked_d = 1'b1;
          end else begin
            locked_d = 1'b0;
            last_d   = owner_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
      last_q   <= 1'b1;
      en_q     <= 1'b0;
      LCD_cs   <= '0;
      LCD_rw   <= 1'b0;
      LCD_di   <= 1'b0;
      LCD_data <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      // Strobe is registered from the next state so it is high exactly while in PULSE.
      en_q     <= (state_d == PULSE);
      if (capture) begin
        LCD_cs   <= sel ? cs1   : cs0;
        LCD_rw   <= sel ? rw1   : rw0;
        LCD_di   <= sel ? di1   : di0;
        LCD_data <= sel ? data1 : data0;
      end
    end
  end

  assign LCD_en = en_q;
  assign busy   = (state_q != IDLE);
  assign gnt0   = (busy || locked_q) && !owner_q;
  assign gnt1   = (busy || locked_q) &&  owner_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: default round-robin instance, a fixed-priority
// instance and a minimum-timing instance.
module tb_lcd_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int tests  = 0;
  int errors = 0;

  // main instance
  logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, rw0 = 0, rw1 = 0, di0 = 0, di1 = 0;
  logic [1:0] cs0 = '0, cs1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, gnt0, gnt1, LCD_rw, LCD_di, LCD_en, busy;
  logic [1:0] LCD_cs;
  logic [7:0] LCD_data;

  lcd_bus_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .cs0(cs0), .cs1(cs1), .rw0(rw0), .rw1(rw1), .di0(di0), .di1(di1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .gnt0(gnt0), .gnt1(gnt1),
    .LCD_cs(LCD_cs), .LCD_rw(LCD_rw), .LCD_di(LCD_di), .LCD_data(LCD_data),
    .LCD_en(LCD_en), .busy(busy)
  );

  // fixed-priority instance
  logic       fp_req0 = 0, fp_req1 = 0;
  logic       fp_ack0, fp_ack1, fp_gnt0, fp_gnt1, fp_rw, fp_di, fp_en, fp_busy;
  logic [1:0] fp_cs;
  logic [7:0] fp_data;

  lcd_bus_arbiter #(.FIXED_PRI(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(fp_req0), .req1(fp_req1), .lock0(1'b0), .lock1(1'b0),
    .cs0(2'b01), .cs1(2'b10), .rw0(1'b0), .rw1(1'b0), .di0(1'b1), .di1(1'b1),
    .data0(8'h5A), .data1(8'hC3),
    .ack0(fp_ack0), .ack1(fp_ack1), .gnt0(fp_gnt0), .gnt1(fp_gnt1),
    .LCD_cs(fp_cs), .LCD_rw(fp_rw), .LCD_di(fp_di), .LCD_data(fp_data),
    .LCD_en(fp_en), .busy(fp_busy)
  );

  // minimum-timing instance
  logic       ft_req0 = 0;
  logic       ft_ack0, ft_ack1, ft_gnt0, ft_gnt1, ft_rw, ft_di, ft_en, ft_busy;
  logic [1:0] ft_cs;
  logic [7:0] ft_data;

  lcd_bus_arbiter #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .req0(ft_req0), .req1(1'b0), .lock0(1'b0), .lock1(1'b0),
    .cs0(2'b11), .cs1(2'b00), .rw0(1'b0), .rw1(1'b0), .di0(1'b0), .di1(1'b0),
    .data0(8'h42), .data1(8'h00),
    .ack0(ft_ack0), .ack1(ft_ack1), .gnt0(ft_gnt0), .gnt1(ft_gnt1),
    .LCD_cs(ft_cs), .LCD_rw(ft_rw), .LCD_di(ft_di), .LCD_data(ft_data),
    .LCD_en(ft_en), .busy(ft_busy)
  );

  typedef struct packed {
    logic        who;
    logic [1:0]  cs;
    logic        rw;
    logic        di;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mutex_viol = 0;
  bit   fp_ack1_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic who, input logic [1:0] cs, input logic rw, input logic di,
                      input logic [7:0] d, input logic [31:0] at);
    exp_t e;
    e.who = who; e.cs = cs; e.rw = rw; e.di = di; e.data = d; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack on the main instance is matched against the next expected transfer.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (gnt0 && gnt1) mutex_viol++;
      if (fp_ack1) fp_ack1_seen = 1'b1;
      if (ack0 || ack1) begin
        a.who = ack1; a.cs = LCD_cs; a.rw = LCD_rw; a.di = LCD_di; a.data = LCD_data; a.cyc = cyc;
        if (ack0 && ack1) chk("ack_both", {ack1, ack0}, 64'h1);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {ack1, ack0}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("xfer", 64'(a), 64'(e));
        end
      end
    end
  end

  task automatic xfer(input logic who, input logic [7:0] d, input logic [1:0] cs, input logic rw,
                      input logic di, input logic lk, input bit keep);
    bit seen = 1'b0;
    if (!who) begin req0 = 1; data0 = d; cs0 = cs; rw0 = rw; di0 = di; lock0 = lk; end
    else      begin req1 = 1; data1 = d; cs1 = cs; rw1 = rw; di1 = di; lock1 = lk; end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) begin seen = 1'b1; break; end
    end
    if (!seen) chk("ack_timeout", 64'(seen), 64'h1);
    @(posedge clk); #1;
    if (!keep) begin
      if (!who) begin req0 = 0; lock0 = 0; end
      else      begin req1 = 0; lock1 = 0; end
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    do_reset();
    @(negedge clk);
    chk("reset_outputs", {ack0, ack1, gnt0, gnt1, LCD_cs, LCD_rw, LCD_di, LCD_data, LCD_en, busy}, 64'h0);
    @(posedge clk); #1;

    fork
      // single write, default timing
      begin
        c = cyc;
        req0 = 1; cs0 = 2'b01; di0 = 1; rw0 = 0; data0 = 8'hA5; lock0 = 0;
        push(0, 2'b01, 0, 1, 8'hA5, c + 12);
        for (int k = 0; k <= 13; k++) begin
          @(negedge clk);
          chk("t1_en", 64'(LCD_en), 64'(k >= 3 && k <= 10));
          chk("t1_busy", 64'(busy), 64'(k >= 1 && k <= 12));
          if (k >= 1) chk("t1_bus", {LCD_cs, LCD_di, LCD_data}, {2'b01, 1'b1, 8'hA5});
          if (k == 12) begin @(posedge clk); #1; req0 = 0; end
        end
      end
      // fixed priority: both held, five transfers all to req0
      begin : fp_blk
        logic [31:0] s;
        bit seen;
        fp_req0 = 1; fp_req1 = 1; s = cyc;
        for (int i = 0; i < 5; i++) begin
          seen = 1'b0;
          for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (fp_ack0 || fp_ack1) begin seen = 1'b1; break; end
          end
          if (!seen) chk("fp_timeout", 64'(seen), 64'h1);
          chk("fp_ack", {fp_ack1, fp_ack0, fp_data, cyc}, {1'b0, 1'b1, 8'h5A, s + 32'd12 + 32'(13 * i)});
          @(posedge clk); #1;
        end
        fp_req0 = 0; fp_req1 = 0;
      end
      // minimum timing: 4-cycle period, one-cycle strobe
      begin
        ft_req0 = 1;
        for (int k = 0; k <= 12; k++) begin
          if (k > 0) begin
            @(posedge clk); #1;
            if (k == 12) ft_req0 = 0;
          end
          @(negedge clk);
          chk("fast_en_ack", {ft_en, ft_ack0}, {1'((k % 4) == 2), 1'(k > 0 && (k % 4) == 3)});
        end
      end
    join

    // round-robin tie from reset
    do_reset();
    c = cyc;
    push(0, 2'b01, 0, 1, 8'h11, c + 12);
    push(1, 2'b10, 1, 0, 8'h21, c + 25);
    push(0, 2'b01, 0, 1, 8'h12, c + 38);
    push(1, 2'b10, 1, 0, 8'h22, c + 51);
    fork
      begin xfer(0, 8'h11, 2'b01, 0, 1, 0, 1); xfer(0, 8'h12, 2'b01, 0, 1, 0, 0); end
      begin xfer(1, 8'h21, 2'b10, 1, 0, 0, 1); xfer(1, 8'h22, 2'b10, 1, 0, 0, 0); end
    join

    // locked burst with req1 pending
    repeat (2) @(posedge clk); #1;
    c = cyc;
    push(0, 2'b01, 0, 1, 8'h10, c + 12);
    push(0, 2'b01, 0, 1, 8'h11, c + 25);
    push(0, 2'b01, 0, 1, 8'h12, c + 38);
    push(1, 2'b10, 0, 1, 8'h99, c + 51);
    fork
      begin
        xfer(0, 8'h10, 2'b01, 0, 1, 1, 1);
        xfer(0, 8'h11, 2'b01, 0, 1, 1, 1);
        xfer(0, 8'h12, 2'b01, 0, 1, 0, 0);
      end
      xfer(1, 8'h99, 2'b10, 0, 1, 0, 0);
      begin : gnt_watch
        int viol = 0;
        for (int k = 0; k <= 40; k++) begin
          @(negedge clk);
          if (k >= 1 && k <= 38 && gnt1) viol++;
          if (k == 13) chk("burst_gnt0_locked_idle", {gnt0, busy}, 64'h2);
          if (k == 40) chk("burst_gnt1_after", 64'(gnt1), 64'h1);
        end
        chk("burst_gnt1_held_off", 64'(viol), 64'h0);
      end
    join

    // reset during PULSE, then req1 alone
    repeat (2) @(posedge clk); #1;
    c = cyc;
    req0 = 1; data0 = 8'h77; cs0 = 2'b01; di0 = 1; lock0 = 0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("rst_pulse_en_before", 64'(LCD_en), 64'h1);
    #1 rst_n = 0;
    #1 chk("rst_pulse_async", {LCD_en, ack0, ack1, busy}, 64'h0);
    req0 = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    c = cyc;
    push(1, 2'b10, 0, 0, 8'h3C, c + 12);
    xfer(1, 8'h3C, 2'b10, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    chk("gnt_mutex", 64'(mutex_viol), 64'h0);
    chk("fp_ack1_never", 64'(fp_ack1_seen), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
